// File: rtl/simd_rf_pkg.sv
// Shared types and helpers for the SIMD register-file bank.
// lane_word supports buses up to 32 lanes of 64 bits.
package simd_rf_pkg;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

   localparam int unsigned LW_BUS_MAX  = 32 * 64;
   localparam int unsigned LW_WORD_MAX = 64;

   // Extract word i of width w from a packed lane bus (zero-extended result).
   function automatic logic [LW_WORD_MAX-1:0] lane_word(
      input logic [LW_BUS_MAX-1:0] bus,
      input int unsigned           i,
      input int unsigned           w
   );
      logic [LW_BUS_MAX-1:0] shifted;
      shifted = bus >> (i * w);
      return shifted[LW_WORD_MAX-1:0] & ((LW_WORD_MAX'(1) << w) - LW_WORD_MAX'(1));
   endfunction

endpackage

// File: rtl/simd_rf_lane.sv
// One SIMD lane: NUM_REGS x DATA_WIDTH storage, two registered read ports with
// write-first bypass and one write port.
module simd_rf_lane #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGS      = 16,
   parameter int LOG2_NUM_REGS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [LOG2_NUM_REGS-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     re_0,
   input  logic [LOG2_NUM_REGS-1:0] raddr_0,
   input  logic                     re_1,
   input  logic [LOG2_NUM_REGS-1:0] raddr_1,
   output logic [DATA_WIDTH-1:0]    rdata_0,
   output logic [DATA_WIDTH-1:0]    rdata_1,
   output logic                     rvalid_0,
   output logic                     rvalid_1
);

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];

   // Storage is deliberately unreset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_0  <= '0;
         rdata_1  <= '0;
         rvalid_0 <= 1'b0;
         rvalid_1 <= 1'b0;
      end else begin
         rvalid_0 <= re_0;
         rvalid_1 <= re_1;
         if (re_0)
            rdata_0 <= (we && waddr == raddr_0) ? wdata : mem[raddr_0];
         if (re_1)
            rdata_1 <= (we && waddr == raddr_1) ? wdata : mem[raddr_1];
      end
   end

endmodule

// File: rtl/simd_regfile_bank.sv
// Multi-lane SIMD register bank: per-lane 2R1W storage with shared addresses,
// scalar-broadcast writes and a clear sweep that runs after reset or on request.
module simd_regfile_bank
   import simd_rf_pkg::*;
#(
   parameter int NUM_LANES     = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGS      = 16,
   parameter int LOG2_NUM_REGS = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_LANES-1:0]            read_en_0,
   input  logic [NUM_LANES-1:0]            read_en_1,
   input  logic [LOG2_NUM_REGS-1:0]        raddr_0,
   input  logic [LOG2_NUM_REGS-1:0]        raddr_1,
   input  logic [NUM_LANES-1:0]            write_en,
   input  logic [LOG2_NUM_REGS-1:0]        waddr,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] wdata,
   input  logic                            wbcast,
   input  logic                            clr_req,
   output logic [NUM_LANES*DATA_WIDTH-1:0] rdata_0,
   output logic [NUM_LANES*DATA_WIDTH-1:0] rdata_1,
   output logic [NUM_LANES-1:0]            rvalid_0,
   output logic [NUM_LANES-1:0]            rvalid_1,
   output logic                            clr_busy,
   output logic                            clr_done
);

   rf_state_t                state_reg;
   logic [LOG2_NUM_REGS-1:0] clr_ptr_reg;
   logic                     clr_done_reg;
   logic [LOG2_NUM_REGS-1:0] lane_waddr;

   assign clr_busy   = (state_reg == RF_CLEAR);
   assign clr_done   = clr_done_reg;
   assign lane_waddr = clr_busy ? clr_ptr_reg : waddr;

   // clr_done is registered one row early so it is high exactly while row NUM_REGS-1 is cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= RF_CLEAR;
         clr_ptr_reg  <= '0;
         clr_done_reg <= 1'b0;
      end else begin
         clr_done_reg <= 1'b0;
         case (state_reg)
            RF_CLEAR: begin
               clr_ptr_reg <= clr_ptr_reg + 1'b1;
               if (clr_ptr_reg == LOG2_NUM_REGS'(NUM_REGS - 2))
                  clr_done_reg <= 1'b1;
               if (clr_ptr_reg == LOG2_NUM_REGS'(NUM_REGS - 1))
                  state_reg <= RF_IDLE;
            end
            default: begin
               if (clr_req) begin
                  state_reg   <= RF_CLEAR;
                  clr_ptr_reg <= '0;
               end
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_wdata;

      assign lane_wdata = clr_busy ? '0 :
         DATA_WIDTH'(lane_word(LW_BUS_MAX'(wdata), wbcast ? 0 : gi, DATA_WIDTH));

      simd_rf_lane #(
         .DATA_WIDTH    (DATA_WIDTH),
         .NUM_REGS      (NUM_REGS),
         .LOG2_NUM_REGS (LOG2_NUM_REGS)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .we       (clr_busy | write_en[gi]),
         .waddr    (lane_waddr),
         .wdata    (lane_wdata),
         .re_0     (read_en_0[gi] & ~clr_busy),
         .raddr_0  (raddr_0),
         .re_1     (read_en_1[gi] & ~clr_busy),
         .raddr_1  (raddr_1),
         .rdata_0  (rdata_0[gi*DATA_WIDTH +: DATA_WIDTH]),
         .rdata_1  (rdata_1[gi*DATA_WIDTH +: DATA_WIDTH]),
         .rvalid_0 (rvalid_0[gi]),
         .rvalid_1 (rvalid_1[gi])
      );
   end

endmodule

// File: tb/tb_simd_regfile_bank.sv
// Randomised and directed bench for simd_regfile_bank against a register-array
// reference model with a simple sweep counter.
module tb_simd_regfile_bank;

   localparam int NL  = 8;
   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int LG  = 4;
   localparam int BUS = NL * DW;

   logic           clk;
   logic           rst;
   logic [NL-1:0]  read_en_0, read_en_1, write_en;
   logic [LG-1:0]  raddr_0, raddr_1, waddr;
   logic [BUS-1:0] wdata;
   logic           wbcast, clr_req;
   logic [BUS-1:0] rdata_0, rdata_1;
   logic [NL-1:0]  rvalid_0, rvalid_1;
   logic           clr_busy, clr_done;

   simd_regfile_bank #(
      .NUM_LANES(NL), .DATA_WIDTH(DW), .NUM_REGS(NR), .LOG2_NUM_REGS(LG)
   ) dut (
      .clk(clk), .rst(rst),
      .read_en_0(read_en_0), .read_en_1(read_en_1),
      .raddr_0(raddr_0), .raddr_1(raddr_1),
      .write_en(write_en), .waddr(waddr), .wdata(wdata),
      .wbcast(wbcast), .clr_req(clr_req),
      .rdata_0(rdata_0), .rdata_1(rdata_1),
      .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
      .clr_busy(clr_busy), .clr_done(clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: register contents plus the number of rows swept so far.
   logic [DW-1:0]  mem_m [NL][NR];
   logic [BUS-1:0] exp_rd0, exp_rd1;
   logic [NL-1:0]  exp_rv0, exp_rv1;
   bit             m_busy;
   int             m_idx;
   int             checks = 0;
   int             errors = 0;
   int             cycle_no = 0;

   task automatic check_eq(input string tag, input logic [BUS-1:0] got, input logic [BUS-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b1;
      m_idx   = 0;
      exp_rd0 = '0;
      exp_rd1 = '0;
      exp_rv0 = '0;
      exp_rv1 = '0;
   endtask

   task automatic model_edge();
      logic [DW-1:0] wv;
      if (m_busy) begin
         for (int l = 0; l < NL; l++) mem_m[l][m_idx] = '0;
         exp_rv0 = '0;
         exp_rv1 = '0;
         m_idx++;
         if (m_idx == NR) m_busy = 1'b0;
      end else begin
         for (int l = 0; l < NL; l++) begin
            wv = wbcast ? wdata[DW-1:0] : wdata[l*DW +: DW];
            exp_rv0[l] = read_en_0[l];
            exp_rv1[l] = read_en_1[l];
            if (read_en_0[l])
               exp_rd0[l*DW +: DW] = (write_en[l] && waddr == raddr_0) ? wv : mem_m[l][raddr_0];
            if (read_en_1[l])
               exp_rd1[l*DW +: DW] = (write_en[l] && waddr == raddr_1) ? wv : mem_m[l][raddr_1];
            if (write_en[l]) mem_m[l][waddr] = wv;
         end
         if (clr_req) begin
            m_busy = 1'b1;
            m_idx  = 0;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".clr_busy"}, BUS'(clr_busy), BUS'(m_busy));
      check_eq({tag, ".clr_done"}, BUS'(clr_done), BUS'(m_busy && m_idx == NR - 1));
      check_eq({tag, ".rdata_0"},  rdata_0, exp_rd0);
      check_eq({tag, ".rdata_1"},  rdata_1, exp_rd1);
      check_eq({tag, ".rvalid_0"}, BUS'(rvalid_0), BUS'(exp_rv0));
      check_eq({tag, ".rvalid_1"}, BUS'(rvalid_1), BUS'(exp_rv1));
   endtask

   task automatic idle_inputs();
      read_en_0 = '0;
      read_en_1 = '0;
      write_en  = '0;
      wbcast    = 1'b0;
      clr_req   = 1'b0;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      cycle_no++;
      model_edge();
      compare_all(tag);
      $display("cyc %0d %s busy=%0b done=%0b rv0=%h rv1=%h", cycle_no, tag, clr_busy, clr_done,
               rvalid_0, rvalid_1);
      idle_inputs();
   endtask

   task automatic rand_wdata();
      for (int l = 0; l < NL; l++) wdata[l*DW +: DW] = $urandom;
   endtask

   task automatic read_all_zero(input string tag);
      for (int r = 0; r < NR; r++) begin
         read_en_0 = '1;
         read_en_1 = '1;
         raddr_0   = LG'(r);
         raddr_1   = LG'(NR - 1 - r);
         step(tag);
         check_eq({tag, ".zero0"}, rdata_0, '0);
         check_eq({tag, ".zero1"}, rdata_1, '0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".rdata_0"},  rdata_0, '0);
      check_eq({tag, ".rdata_1"},  rdata_1, '0);
      check_eq({tag, ".rvalid"},   BUS'({rvalid_1, rvalid_0}), '0);
      check_eq({tag, ".clr_busy"}, BUS'(clr_busy), BUS'(1'b1));
      check_eq({tag, ".clr_done"}, BUS'(clr_done), '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [BUS-1:0] exp_bus;
      logic [NL-1:0]  mask;
      int             busy_cnt;
      int             wait_cnt;

      rst = 1'b1;
      idle_inputs();
      raddr_0 = '0;
      raddr_1 = '0;
      waddr   = '0;
      wdata   = '0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      rst = 1'b0;

      // 1: power-up sweep, then everything reads zero
      repeat (NR) step("t1_sweep");
      read_all_zero("t1_read");

      // 2: single-lane write then read on port 1
      rand_wdata();
      wdata[3*DW +: DW] = 32'hDEAD_BEEF;
      write_en = 8'h08;
      waddr    = 4'd5;
      step("t2_write");
      read_en_1 = '1;
      raddr_1   = 4'd5;
      step("t2_read");
      exp_bus = '0;
      exp_bus[3*DW +: DW] = 32'hDEAD_BEEF;
      check_eq("t2_lane3", rdata_1, exp_bus);

      // 3: same-cycle write/read bypass
      for (int l = 0; l < NL; l++) wdata[l*DW +: DW] = DW'(32'h10 + l);
      write_en  = '1;
      waddr     = 4'd7;
      read_en_0 = '1;
      raddr_0   = 4'd7;
      step("t3_bypass");
      for (int l = 0; l < NL; l++) exp_bus[l*DW +: DW] = DW'(32'h10 + l);
      check_eq("t3_bypass_data", rdata_0, exp_bus);

      // 4: broadcast write to a lane subset
      rand_wdata();
      wdata[DW-1:0] = 32'h1234;
      wbcast    = 1'b1;
      write_en  = 8'hA5;
      waddr     = 4'd7;
      step("t4_bcast");
      read_en_0 = '1;
      raddr_0   = 4'd7;
      step("t4_read");
      mask = 8'hA5;
      for (int l = 0; l < NL; l++)
         exp_bus[l*DW +: DW] = mask[l] ? 32'h1234 : DW'(32'h10 + l);
      check_eq("t4_bcast_data", rdata_0, exp_bus);

      // random traffic with occasional clear requests
      for (int c = 0; c < 400; c++) begin
         read_en_0 = NL'($urandom);
         read_en_1 = NL'($urandom);
         raddr_0   = LG'($urandom);
         raddr_1   = LG'($urandom);
         write_en  = NL'($urandom);
         waddr     = LG'($urandom_range(0, 3) == 0 ? raddr_0 : $urandom);
         rand_wdata();
         wbcast    = ($urandom_range(0, 3) == 0);
         clr_req   = ($urandom_range(0, 49) == 0);
         step("rand");
      end

      // 5: clear with concurrent write, clr_req re-pulsed mid-sweep
      wait_cnt = 0;
      while (m_busy && wait_cnt < 40) begin
         step("t5_wait");
         wait_cnt++;
      end
      check_eq("t5_wait_bound", BUS'(clr_busy), '0);
      rand_wdata();
      write_en = '1;
      waddr    = 4'd3;
      clr_req  = 1'b1;
      step("t5_req");
      busy_cnt = clr_busy ? 1 : 0;
      for (int k = 0; k < NR; k++) begin
         read_en_0 = '1;
         read_en_1 = NL'($urandom);
         raddr_0   = LG'($urandom);
         raddr_1   = LG'($urandom);
         write_en  = NL'($urandom);
         rand_wdata();
         clr_req   = (k == 5);
         step("t5_sweep");
         if (clr_busy) busy_cnt++;
         if (k < NR - 1) check_eq("t5_rvalid_mid", BUS'(rvalid_0), '0);
      end
      check_eq("t5_busy_cycles", BUS'(busy_cnt), BUS'(NR));
      read_all_zero("t5_read");

      // 6: asynchronous reset in the middle of a sweep
      clr_req = 1'b1;
      step("t6_req");
      repeat (6) step("t6_sweep");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("t6_reset");
      #2;
      rst = 1'b0;
      busy_cnt = clr_busy ? 1 : 0;
      repeat (NR) begin
         step("t6_resweep");
         if (clr_busy) busy_cnt++;
      end
      check_eq("t6_busy_cycles", BUS'(busy_cnt), BUS'(NR));
      read_all_zero("t6_read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
